// File: rtl/cfg_mon_pkg.sv
// Shared states, field indices and default limits for the
// configuration range monitor.
package cfg_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_OK,
    ST_FAULT
  } cfg_state_e;

  localparam int FLD_SLAVE_CNT = 0;
  localparam int FLD_AVE_DELAY = 1;

  localparam int DEF_SLAVE_CNT_MIN = 1;
  localparam int DEF_SLAVE_CNT_MAX = 30;
  localparam int DEF_AVE_DELAY_MIN = 50;
  localparam int DEF_AVE_DELAY_MAX = 70;

  // Counter width able to hold n-1 with one bit of headroom.
  function automatic int cnt_width(int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/cfg_field_cmp.sv
// Inclusive unsigned range check of one configuration field.
// An inverted limit pair never counts as in range.
module cfg_field_cmp #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] field_i,
  input  logic [WIDTH-1:0] min_i,
  input  logic [WIDTH-1:0] max_i,
  output logic             in_range_o,
  output logic             limit_err_o
);

  always_comb begin
    limit_err_o = min_i > max_i;
    in_range_o  = !limit_err_o
                  && (field_i >= min_i)
                  && (field_i <= max_i);
  end

endmodule

// File: rtl/cfg_range_monitor.sv
// Configuration qualifier: range/stability check with sticky faults.
// Optional settle timeout enabled by defining CFG_MON_TIMEOUT_EN.
module cfg_range_monitor
  import cfg_mon_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int NUM_FIELDS     = 2,
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        Clk,
  input  logic                        Reset_n,
  input  logic                        Enable,
  input  logic                        ClearFault,
  input  logic [NUM_FIELDS*WIDTH-1:0] Fields,
  input  logic [NUM_FIELDS*WIDTH-1:0] MinLimit,
  input  logic [NUM_FIELDS*WIDTH-1:0] MaxLimit,
  output logic                        ConfigOK,
  output logic                        Fault,
  output logic [NUM_FIELDS-1:0]       FaultMask,
  output logic [NUM_FIELDS-1:0]       LimitErr,
  output logic                        Timeout
);

  localparam int CNT_W = cnt_width(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(STABLE_CYCLES - 1);

  cfg_state_e                  state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [NUM_FIELDS*WIDTH-1:0] fields_q, fields_d;
  logic [NUM_FIELDS-1:0]       mask_q, mask_d;
  logic [NUM_FIELDS-1:0]       in_range;
  logic                        tmo_q, tmo_d;
  logic                        all_in;
  logic                        qualify;
  logic                        settle_done;
  logic                        settle_expired;

  for (genvar i = 0; i < NUM_FIELDS; i++) begin : g_cmp
    cfg_field_cmp #(
      .WIDTH(WIDTH)
    ) u_cmp (
      .field_i    (fields_q[i*WIDTH +: WIDTH]),
      .min_i      (MinLimit[i*WIDTH +: WIDTH]),
      .max_i      (MaxLimit[i*WIDTH +: WIDTH]),
      .in_range_o (in_range[i]),
      .limit_err_o(LimitErr[i])
    );
  end

  // Stable means the live inputs match last cycle's sample.
  assign all_in      = &in_range;
  assign qualify     = all_in && (Fields == fields_q);
  assign settle_done = qualify && (cnt_q == CNT_LAST);

`ifdef CFG_MON_TIMEOUT_EN
  localparam int WAIT_W = cnt_width(TIMEOUT_CYCLES);
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    WAIT_W'(TIMEOUT_CYCLES - 1);

  logic [WAIT_W-1:0] wait_q, wait_d;

  assign settle_expired = (state_q == ST_SETTLE)
                          && (wait_q == WAIT_LAST);

  always_comb begin
    wait_d = '0;
    if (state_q == ST_SETTLE && state_d == ST_SETTLE)
      wait_d = wait_q + WAIT_W'(1);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) wait_q <= '0;
    else          wait_q <= wait_d;
  end
`else
  assign settle_expired = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    mask_d   = mask_q;
    tmo_d    = tmo_q;
    fields_d = Fields;
    unique case (state_q)
      ST_IDLE: state_d = ST_SETTLE;
      ST_SETTLE: begin
        if (settle_done) begin
          state_d = ST_OK;
        end else if (settle_expired) begin
          state_d = ST_FAULT;
          tmo_d   = 1'b1;
        end else if (qualify) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_OK: begin
        if (!all_in) begin
          state_d = ST_FAULT;
          mask_d  = mask_q | ~in_range;
        end
      end
      ST_FAULT: if (ClearFault) state_d = ST_SETTLE;
      default:  state_d = ST_IDLE;
    endcase
    if (!Enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      mask_d  = mask_q;
      tmo_d   = tmo_q;
    end
    if (ClearFault) begin
      mask_d = '0;
      tmo_d  = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      mask_q   <= '0;
      tmo_q    <= 1'b0;
      fields_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
      tmo_q    <= tmo_d;
      fields_q <= fields_d;
    end
  end

  assign ConfigOK  = (state_q == ST_OK);
  assign Fault     = (state_q == ST_FAULT);
  assign FaultMask = mask_q;
  assign Timeout   = tmo_q;

endmodule

// File: tb/tb_cfg_range_monitor.sv
// Directed and randomized checks of cfg_range_monitor against
// a cycle model built from the qualification rules.
module tb_cfg_range_monitor;

  localparam int W = 8;
  localparam int N = 2;
  localparam int S = 4;
  localparam int T = 16;

  logic           Clk = 1'b0;
  logic           Reset_n;
  logic           Enable;
  logic           ClearFault;
  logic [N*W-1:0] Fields;
  logic [N*W-1:0] MinLimit;
  logic [N*W-1:0] MaxLimit;
  logic           ConfigOK;
  logic           Fault;
  logic [N-1:0]   FaultMask;
  logic [N-1:0]   LimitErr;
  logic           Timeout;

  int n_cmp = 0;
  int n_bad = 0;

  // model: phase 0 idle, 1 settle, 2 ok, 3 fault
  int     m_phase;
  int     m_run;
  int     m_wait;
  int     m_tmo;
  int     m_fq[N];
  bit [N-1:0] m_mask;

  always #5 Clk = ~Clk;

  cfg_range_monitor #(
    .WIDTH         (W),
    .NUM_FIELDS    (N),
    .STABLE_CYCLES (S),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Enable    (Enable),
    .ClearFault(ClearFault),
    .Fields    (Fields),
    .MinLimit  (MinLimit),
    .MaxLimit  (MaxLimit),
    .ConfigOK  (ConfigOK),
    .Fault     (Fault),
    .FaultMask (FaultMask),
    .LimitErr  (LimitErr),
    .Timeout   (Timeout)
  );

  function automatic int fld(logic [N*W-1:0] v, int i);
    logic [W-1:0] s;
    s = v[i*W +: W];
    return int'(s);
  endfunction

  function automatic logic [N-1:0] lerr_exp();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++)
      r[i] = fld(MinLimit, i) > fld(MaxLimit, i);
    return r;
  endfunction

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_run   = 0;
    m_wait  = 0;
    m_tmo   = 0;
    m_mask  = '0;
    for (int i = 0; i < N; i++) m_fq[i] = 0;
  endtask

  task automatic model_step();
    bit inr[N];
    bit all_in;
    bit same;
    all_in = 1'b1;
    same   = 1'b1;
    for (int i = 0; i < N; i++) begin
      inr[i] = (fld(MinLimit, i) <= m_fq[i])
               && (m_fq[i] <= fld(MaxLimit, i));
      all_in = all_in && inr[i];
      same   = same && (fld(Fields, i) == m_fq[i]);
    end
    if (!Enable) begin
      m_phase = 0;
      m_run   = 0;
      m_wait  = 0;
    end else begin
      case (m_phase)
        0: begin
          m_phase = 1;
          m_run   = 0;
          m_wait  = 0;
        end
        1: begin
          m_run  = (all_in && same) ? m_run + 1 : 0;
          m_wait = m_wait + 1;
          if (m_run == S) begin
            m_phase = 2;
            m_run   = 0;
            m_wait  = 0;
          end
`ifdef CFG_MON_TIMEOUT_EN
          else if (m_wait == T) begin
            m_phase = 3;
            m_tmo   = 1;
            m_run   = 0;
            m_wait  = 0;
          end
`endif
        end
        2: begin
          if (!all_in) begin
            m_phase = 3;
            for (int i = 0; i < N; i++)
              if (!inr[i]) m_mask[i] = 1'b1;
          end
        end
        default: begin
          if (ClearFault) begin
            m_phase = 1;
            m_run   = 0;
            m_wait  = 0;
          end
        end
      endcase
    end
    if (ClearFault) begin
      m_mask = '0;
      m_tmo  = 0;
    end
    for (int i = 0; i < N; i++) m_fq[i] = fld(Fields, i);
  endtask

  task automatic tick();
    model_step();
    @(posedge Clk);
    #1;
    chk("m_cfgok", ConfigOK, m_phase == 2);
    chk("m_fault", Fault, m_phase == 3);
    chk("m_mask", FaultMask, m_mask);
    chk("m_tmo", Timeout, m_tmo);
    chk("m_lerr", LimitErr, lerr_exp());
  endtask

  task automatic set_default_limits();
    MinLimit = {8'd50, 8'd1};
    MaxLimit = {8'd70, 8'd30};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int bf0[8]  = '{1, 30, 10, 10, 0, 31, 10, 10};
  int bf1[8]  = '{60, 60, 50, 70, 60, 60, 49, 71};
  int bok[8]  = '{1, 1, 1, 1, 0, 0, 0, 0};
  int f0v[7]  = '{0, 1, 2, 15, 29, 30, 31};
  int f1v[7]  = '{49, 50, 51, 60, 69, 70, 71};
  int n;

  initial begin
    Reset_n    = 1'b0;
    Enable     = 1'b0;
    ClearFault = 1'b0;
    Fields     = '0;
    set_default_limits();
    model_reset();
    #12;
    chk("rst_cfgok", ConfigOK, 0);
    chk("rst_fault", Fault, 0);
    chk("rst_mask", FaultMask, 0);
    chk("rst_tmo", Timeout, 0);
    Reset_n = 1'b1;

    // qualify latency from Enable
    Fields = {8'd60, 8'd10};
    tick();
    Enable = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("en_lat", ConfigOK, k == 5);
    end
    chk("en_fault", Fault, 0);
    chk("en_mask", FaultMask, 0);

    // out of range while OK
    Fields[15:8] = 8'd71;
    tick();
    chk("oor_e1", ConfigOK, 1);
    tick();
    chk("oor_cfgok", ConfigOK, 0);
    chk("oor_fault", Fault, 1);
    chk("oor_mask", FaultMask, 2'b10);

    // restore and clear
    Fields[15:8] = 8'd60;
    tick();
    ClearFault = 1'b1;
    tick();
    ClearFault = 1'b0;
    chk("clr_mask", FaultMask, 0);
    for (int k = 2; k <= 5; k++) begin
      tick();
      chk("clr_lat", ConfigOK, k == 5);
    end

    // toggling field stays in SETTLE
    Enable = 1'b0;
    tick();
    Enable = 1'b1;
    tick();
    for (int c = 0; c < 12; c++) begin
      if (c % 2 == 0)
        Fields[7:0] = (Fields[7:0] == 8'd10) ? 8'd11 : 8'd10;
      tick();
      chk("tog_cfgok", ConfigOK, 0);
      chk("tog_mask", FaultMask, 0);
    end
    n = 0;
    while (!ConfigOK && n < 8) begin
      tick();
      n++;
    end
    chk("tog_lat", n, 3);

    // boundary values
    for (int b = 0; b < 8; b++) begin
      Enable     = 1'b0;
      Fields     = {8'(bf1[b]), 8'(bf0[b])};
      ClearFault = 1'b1;
      tick();
      ClearFault = 1'b0;
      Enable     = 1'b1;
      repeat (6) tick();
      chk("bnd_cfgok", ConfigOK, bok[b]);
      chk("bnd_fault", Fault, 0);
    end

    // inverted limits on field 0
    Enable        = 1'b0;
    Fields        = {8'd60, 8'd10};
    MinLimit[7:0] = 8'd40;
    MaxLimit[7:0] = 8'd20;
    #1;
    chk("lerr_now", LimitErr, 2'b01);
    tick();
    Enable = 1'b1;
    tick();
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk("lerr_cfgok", ConfigOK, 0);
`ifdef CFG_MON_TIMEOUT_EN
      chk("tmo_fault", Fault, k >= 16);
      chk("tmo_flag", Timeout, k >= 16);
`else
      chk("notmo_fault", Fault, 0);
      chk("notmo_flag", Timeout, 0);
`endif
      chk("lerr_mask", FaultMask, 0);
    end
    set_default_limits();
    Enable     = 1'b0;
    ClearFault = 1'b1;
    tick();
    ClearFault = 1'b0;

    // asynchronous reset while OK
    Enable = 1'b1;
    repeat (5) tick();
    chk("ar_pre", ConfigOK, 1);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("ar_cfgok", ConfigOK, 0);
    chk("ar_fault", Fault, 0);
    model_reset();
    #2;
    Reset_n = 1'b1;

    // Enable dropped in FAULT keeps the mask
    repeat (7) tick();
    chk("ed_pre", ConfigOK, 1);
    Fields[15:8] = 8'd71;
    repeat (2) tick();
    chk("ed_fault", Fault, 1);
    Enable = 1'b0;
    tick();
    chk("ed_idle", Fault, 0);
    chk("ed_cfgok", ConfigOK, 0);
    chk("ed_mask", FaultMask, 2'b10);
    Fields[15:8] = 8'd60;

    // randomized traffic against the model
    for (int r = 0; r < 400; r++) begin
      if ($urandom_range(0, 3) == 0)
        Fields[7:0] = 8'(f0v[$urandom_range(0, 6)]);
      if ($urandom_range(0, 3) == 0)
        Fields[15:8] = 8'(f1v[$urandom_range(0, 6)]);
      Enable     = ($urandom_range(0, 19) != 0);
      ClearFault = ($urandom_range(0, 15) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
